// File: rtl/fetch_pkg.sv
// Shared types for the RV32I instruction-fetch stage: FSM state encoding and bus widths.
package fetch_pkg;

  localparam int FETCH_STATE_W = 3;
  localparam int INST_ADDR_W   = 32;
  localparam int INST_W        = 32;

  typedef enum logic [FETCH_STATE_W-1:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    FETCH3 = 3'd3,
    HOLD   = 3'd4
  } fetch_state_e;

  // FETCHk encodes k in its low two bits, giving the byte offset of the request.
  function automatic logic [1:0] byte_index(fetch_state_e s);
    logic [FETCH_STATE_W-1:0] v;
    v = s;
    return v[1:0];
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: byte-wide memory read port, redirect input and IF/ID output.
interface fetch_if;
  import fetch_pkg::*;

  logic                   stall_i;
  logic                   branch_i;
  logic [INST_ADDR_W-1:0] branch_target_i;
  logic                   mem_req_o;
  logic [INST_ADDR_W-1:0] mem_addr_o;
  logic                   mem_valid_i;
  logic [7:0]             mem_data_i;
  logic [INST_ADDR_W-1:0] pc_o;
  logic [INST_W-1:0]      inst_o;
  logic                   inst_valid_o;

  modport master (
    input  stall_i, branch_i, branch_target_i, mem_valid_i, mem_data_i,
    output mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o
  );

  modport slave (
    output stall_i, branch_i, branch_target_i, mem_valid_i, mem_data_i,
    input  mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o
  );
endinterface

// File: rtl/fetch_icache.sv
// Direct-mapped word I-cache for the fetch stage; combinational lookup, single-cycle fill.
module fetch_icache
  import fetch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INST_ADDR_W-1:0] lookup_addr,
  output logic                   lookup_hit,
  output logic [INST_W-1:0]      lookup_data,
  input  logic                   fill_we,
  input  logic [INST_ADDR_W-1:0] fill_addr,
  input  logic [INST_W-1:0]      fill_data
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = INST_ADDR_W - 2 - IDX_W;

  logic [ENTRIES-1:0] line_valid;
  logic [TAG_W-1:0]   tags  [ENTRIES];
  logic [INST_W-1:0]  words [ENTRIES];

  logic [IDX_W-1:0] lookup_idx, fill_idx;
  logic [TAG_W-1:0] lookup_tag, fill_tag;
  logic             unused_low;

  assign lookup_idx = lookup_addr[IDX_W+1:2];
  assign lookup_tag = lookup_addr[INST_ADDR_W-1:IDX_W+2];
  assign fill_idx   = fill_addr[IDX_W+1:2];
  assign fill_tag   = fill_addr[INST_ADDR_W-1:IDX_W+2];
  assign unused_low = ^{lookup_addr[1:0], fill_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid <= '0;
    end else if (fill_we) begin
      line_valid[fill_idx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset; the valid bits gate every hit.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tags[fill_idx]  <= fill_tag;
      words[fill_idx] <= fill_data;
    end
  end

  assign lookup_hit  = line_valid[lookup_idx] & (tags[lookup_idx] == lookup_tag);
  assign lookup_data = words[lookup_idx];

endmodule

// File: rtl/fetch.sv
// RV32I fetch stage: four little-endian byte reads per instruction, held until consumed.
// Optional I-cache enabled by defining FETCH_ICACHE_EN.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC       = 32'h0000_0000,
  parameter int                     ICACHE_ENTRIES = 16
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);
  // state  | meaning
  // FETCH0 | requesting byte 0 at pc (or cache lookup)
  // FETCH1 | requesting byte 1 at pc+1
  // FETCH2 | requesting byte 2 at pc+2
  // FETCH3 | requesting byte 3 at pc+3
  // HOLD   | instruction presented, waiting for consume

  fetch_state_e           state, state_next;
  logic [INST_ADDR_W-1:0] pc;
  logic [INST_ADDR_W-1:0] target;
  logic                   started;
  logic [23:0]            asm_bytes;
  logic [INST_ADDR_W-1:0] pc_q;
  logic [INST_W-1:0]      inst_q;
  logic                   valid_q;
  logic                   req;
  logic [INST_ADDR_W-1:0] addr;
  logic                   accept, consume, hit;
  logic [INST_W-1:0]      hit_data;
  logic                   unused_cfg;

  assign target     = {bus.branch_target_i[31:2], 2'b00};
  assign accept     = req & bus.mem_valid_i;
  assign consume    = valid_q & ~bus.stall_i;
  assign unused_cfg = ^{bus.branch_target_i[1:0], ICACHE_ENTRIES[0]};

`ifdef FETCH_ICACHE_EN
  logic hit_raw;
  logic fill_we;

  // Fill only on a clean miss completion; a same-cycle branch cancels it.
  assign fill_we = (state == FETCH3) & accept & ~bus.branch_i;
  assign hit     = started & (state == FETCH0) & hit_raw;

  fetch_icache #(.ENTRIES(ICACHE_ENTRIES)) u_icache (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (pc),
    .lookup_hit  (hit_raw),
    .lookup_data (hit_data),
    .fill_we     (fill_we),
    .fill_addr   (pc),
    .fill_data   ({bus.mem_data_i, asm_bytes})
  );
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.branch_i) begin
      state_next = FETCH0;
    end else begin
      case (state)
        FETCH0:  if (hit) state_next = HOLD;
                 else if (accept) state_next = FETCH1;
        FETCH1:  if (accept) state_next = FETCH2;
        FETCH2:  if (accept) state_next = FETCH3;
        FETCH3:  if (accept) state_next = HOLD;
        HOLD:    if (consume) state_next = FETCH0;
        default: state_next = FETCH0;
      endcase
    end
  end

  // started keeps the request low until the first edge after reset release.
  always_comb begin
    req  = 1'b0;
    addr = '0;
    if (started && (state != HOLD) && !hit) begin
      req  = 1'b1;
      addr = pc + {30'b0, byte_index(state)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      started   <= 1'b0;
      asm_bytes <= '0;
      pc_q      <= '0;
      inst_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      started <= 1'b1;
      if (bus.branch_i) begin
        pc      <= target;
        valid_q <= 1'b0;
      end else if (hit) begin
        inst_q  <= hit_data;
        pc_q    <= pc;
        valid_q <= 1'b1;
      end else if (accept) begin
        case (state)
          FETCH0:  asm_bytes[7:0]   <= bus.mem_data_i;
          FETCH1:  asm_bytes[15:8]  <= bus.mem_data_i;
          FETCH2:  asm_bytes[23:16] <= bus.mem_data_i;
          FETCH3: begin
            inst_q  <= {bus.mem_data_i, asm_bytes};
            pc_q    <= pc;
            valid_q <= 1'b1;
          end
          default: ;
        endcase
      end else if (consume) begin
        pc      <= pc + 32'd4;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.mem_req_o    = req;
  assign bus.mem_addr_o   = addr;
  assign bus.pc_o         = pc_q;
  assign bus.inst_o       = inst_q;
  assign bus.inst_valid_o = valid_q;

endmodule
